// File: rtl/avalon_adapter_pkg.sv
// Shared definitions for the SDRAM-side Avalon-MM width adapters.
// Holds the write-adapter state encoding and the default bus widths.
package avalon_adapter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int S_DATA_W     = 32;
  localparam int M_DATA_W     = 16;
  localparam int S_BE_W       = S_DATA_W / 8;
  localparam int M_BE_W       = M_DATA_W / 8;
  localparam int M_ADDR_W_DEF = 25;

endpackage

// File: rtl/avalon_mm_32_to_16_write_adapter.sv
// avalon_mm_32_to_16_write_adapter
// Splits one 32-bit Avalon-MM write into two sequential 16-bit writes to the
// SDRAM controller slave, stalling the 32-bit master until both are accepted.
//
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   s_address            32-bit byte address from the master ([1:0] ignored)
//   s_write              write request, held while s_waitrequest is high
//   s_writedata          32-bit write data ([15:0] low half, [31:16] high half)
//   s_byteenable         active-high byte enables
//   s_waitrequest        stall to the master
//   m_address            halfword address to the controller
//   m_write/m_chipselect write strobe (identical)
//   m_writedata          16-bit halfword data
//   m_byteenable_n       active-low halfword byte enables
//   m_waitrequest        controller stall
//
// Build option: ADAPTER_SKIP_EMPTY_HALF_EN -- when defined, a halfword beat
// whose byte enables are all zero is not issued.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for s_write; latch base address, data, byteenable
// ST_LO   | low halfword beat on the master port
// ST_HI   | high halfword beat on the master port
// ST_DONE | release the master (s_waitrequest low for one cycle)
module avalon_mm_32_to_16_write_adapter
  import avalon_adapter_pkg::*;
#(
  parameter int M_ADDR_W = M_ADDR_W_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         s_address,
  input  logic                s_write,
  input  logic [S_DATA_W-1:0] s_writedata,
  input  logic [S_BE_W-1:0]   s_byteenable,
  output logic                s_waitrequest,
  output logic [M_ADDR_W-1:0] m_address,
  output logic                m_write,
  output logic                m_chipselect,
  output logic [M_DATA_W-1:0] m_writedata,
  output logic [M_BE_W-1:0]   m_byteenable_n,
  input  logic                m_waitrequest
);

  state_t                r_state;
  state_t                w_next;
  logic [M_ADDR_W-1:0]   r_base;
  logic [S_DATA_W-1:0]   r_data;
  logic [S_BE_W-1:0]     r_be;
  logic [M_ADDR_W-1:0]   w_base;
  logic                  w_unused_addr;

  // Byte address -> even halfword address of the 32-bit word.
  assign w_base        = {s_address[M_ADDR_W:2], 1'b0};
  assign w_unused_addr = ^{s_address[31:M_ADDR_W+1], s_address[1:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_base  <= '0;
      r_data  <= '0;
      r_be    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && s_write) begin
        r_base <= w_base;
        r_data <= s_writedata;
        r_be   <= s_byteenable;
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    m_write        = 1'b0;
    m_address      = '0;
    m_writedata    = '0;
    m_byteenable_n = '1;
    case (r_state)
      ST_IDLE: begin
        if (s_write) begin
          w_next = ST_LO;
`ifdef ADAPTER_SKIP_EMPTY_HALF_EN
          if (s_byteenable[1:0] == 2'b00)
            w_next = (s_byteenable[3:2] == 2'b00) ? ST_DONE : ST_HI;
`endif
        end
      end
      ST_LO: begin
        m_write        = 1'b1;
        m_address      = r_base;
        m_writedata    = r_data[15:0];
        m_byteenable_n = ~r_be[1:0];
        if (!m_waitrequest) begin
          w_next = ST_HI;
`ifdef ADAPTER_SKIP_EMPTY_HALF_EN
          if (r_be[3:2] == 2'b00) w_next = ST_DONE;
`endif
        end
      end
      ST_HI: begin
        m_write        = 1'b1;
        // base is even, so setting bit 0 is base+1 without a carry chain
        m_address      = {r_base[M_ADDR_W-1:1], 1'b1};
        m_writedata    = r_data[31:16];
        m_byteenable_n = ~r_be[3:2];
        if (!m_waitrequest) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign m_chipselect  = m_write;
  assign s_waitrequest = s_write && (r_state != ST_DONE);

endmodule
